// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared types and constants for the systolic array controller
//
// Purpose: controller state encoding, array datapath widths and a small
// helper for select-field widths. No ports; imported by the RTL files.

package systola_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 12;

    // Width of a field that selects one of n items; never narrower than 1 bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systola_skew.sv
// rtl/systola_skew.sv - fixed-depth delay line with synchronous flush
//
// Purpose: delays a W-bit value by DEPTH cycles. Used for the per-row fire
// skew and equally usable for operand-data skew.
// Ports:
//   clk    in  1   clock, posedge
//   rst    in  1   synchronous active-high reset, clears all stages
//   flush  in  1   synchronous clear of all stages (job abort)
//   din    in  W   value entering the delay line
//   dout   out W   din delayed by DEPTH cycles (DEPTH >= 1)

module systola_skew
    import systola_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for a ROWS x COLS systolic MAC array
//
// Purpose: per job, clears the PE accumulators, streams K operand-buffer
// reads with skewed per-row fire into column 0, waits for the fire wave to
// cross the array, drains one row per cycle and pulses done.
// Ports:
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous active-high reset
//   start      in   1      job request, sampled only in IDLE
//   k_len      in   KW     reduction length K, captured with start
//   abort      in   1      abandon the current job
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle completion pulse (not on abort)
//   pe_rstn    out  1      active-low accumulator clear to all PEs
//   rd_en      out  1      operand-buffer read strobe (row-0 timing)
//   rd_idx     out  KW     k index of the current read
//   fire_row   out  ROWS   column-0 fire, row r delayed r cycles
//   out_valid  out  1      drain strobe
//   out_sel    out  >=1    row being drained

module systolic_ctrl
    import systola_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [KW-1:0]                k_len,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         pe_rstn,
    output logic                         rd_en,
    output logic [KW-1:0]                rd_idx,
    output logic [ROWS-1:0]              fire_row,
    output logic                         out_valid,
    output logic [sel_width(ROWS)-1:0]   out_sel
);

    localparam int SELW = sel_width(ROWS);
    // Stream counter covers K plus the array skew with a spare bit, so it
    // cannot wrap even at the largest K.
    localparam int SW   = KW + $clog2(ROWS + COLS) + 1;
    localparam logic [SELW-1:0] LAST_ROW = SELW'(ROWS - 1);

    ctrl_state_t     state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic [SELW-1:0] drain_q, drain_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pe_rstn_q, pe_rstn_d;
    logic            rd_en_q, rd_en_d;
    logic [KW-1:0]   rd_idx_q, rd_idx_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;

    logic            flush;
    logic [SW-1:0]   s_last;

    assign flush  = abort && (state_q != IDLE);
    // Last stream cycle: the final accumulate of PE(ROWS-1, COLS-1).
    assign s_last = SW'(k_q) + SW'(ROWS + COLS - 2) - SW'(1);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        drain_d     = drain_q;
        done_d      = 1'b0;
        pe_rstn_d   = 1'b1;
        rd_en_d     = 1'b0;
        rd_idx_d    = '0;
        out_valid_d = 1'b0;
        out_sel_d   = '0;

        // Outputs are computed for the state being entered, so every
        // strobe is a flop that lines up with its state.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    k_d       = k_len;
                    pe_rstn_d = 1'b0;
                end
            end
            CLEAR: begin
                s_d     = '0;
                drain_d = '0;
                if (k_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = STREAM;
                    rd_en_d = 1'b1;
                end
            end
            STREAM: begin
                if (s_q == s_last) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                end else begin
                    s_d = s_q + SW'(1);
                    if (s_d < SW'(k_q)) begin
                        rd_en_d  = 1'b1;
                        rd_idx_d = s_d[KW-1:0];
                    end
                end
            end
            DRAIN: begin
                if (drain_q == LAST_ROW) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d     = drain_q + SELW'(1);
                    out_valid_d = 1'b1;
                    out_sel_d   = drain_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            pe_rstn_d   = 1'b0;
            rd_en_d     = 1'b0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            s_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_rstn_q   <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_rstn_q   <= pe_rstn_d;
            rd_en_q     <= rd_en_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    // Row 0 fires with the read strobe; row r sees the same pulse train r
    // cycles later. Abort flushes the skew lines so no stray fire escapes.
    assign fire_row[0] = rd_en_q;

    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        systola_skew #(
            .W     (1),
            .DEPTH (r)
        ) u_skew (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .din   (rd_en_q),
            .dout  (fire_row[r])
        );
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pe_rstn   = pe_rstn_q;
    assign rd_en     = rd_en_q;
    assign rd_idx    = rd_idx_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl with a behavioural PE array

module tb_systolic_ctrl;
    import systola_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            abort;
    logic            busy;
    logic            done;
    logic            pe_rstn;
    logic            rd_en;
    logic [KW-1:0]   rd_idx;
    logic [ROWS-1:0] fire_row;
    logic            out_valid;
    logic [1:0]      out_sel;

    systolic_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS),
        .KW   (KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .pe_rstn   (pe_rstn),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .fire_row  (fire_row),
        .out_valid (out_valid),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_ov[$];
    ev_t q_done[$];
    ev_t q_pr[$];
    int  q_fire[ROWS][$];

    int  n_chk    = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    int  done_cnt = 0;
    bit  prev_done = 1'b0;
    int  op_val   = 1;
    int  exp_acc  = 0;
    ev_t e;

    logic [ACC_W-1:0] acc_m [ROWS][COLS];
    logic             pe_fq [ROWS][COLS];

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int v);
        ev_t t;
        t.cyc = c;
        t.val = v;
        return t;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array: fire enters column 0 from fire_row and moves east one
    // column per cycle; every fired PE adds op_val*op_val, wrapping at 12 bits.
    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pe_fq[r][c] = 1'b0;
    end

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic fin;
                if (c == 0) fin = fire_row[r];
                else        fin = pe_fq[r][c-1];
                pe_fq[r][c] <= fin;
                if (!pe_rstn)  acc_m[r][c] <= '0;
                else if (fin)  acc_m[r][c] <= acc_m[r][c] + ACC_W'(op_val * op_val);
            end
        end
    end

    // Scoreboard consumer: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_done) chk("busy_after_done", int'(busy), 0);
            prev_done = done;
            if (rd_en) begin
                if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_idx", int'(rd_idx), e.val);
                end
            end
            if (!pe_rstn) begin
                if (q_pr.size() == 0) chk("pe_rstn_unexpected", 1, 0);
                else begin
                    e = q_pr.pop_front();
                    chk("pe_rstn_cyc", cyc, e.cyc);
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (fire_row[r]) begin
                    if (q_fire[r].size() == 0) chk("fire_unexpected", r, -1);
                    else chk("fire_cyc", cyc, q_fire[r].pop_front());
                end
            end
            if (out_valid) begin
                if (q_ov.size() == 0) chk("ov_unexpected", 1, 0);
                else begin
                    e = q_ov.pop_front();
                    chk("ov_cyc", cyc, e.cyc);
                    chk("out_sel", int'(out_sel), e.val);
                    for (int c = 0; c < COLS; c++)
                        chk("acc", int'(acc_m[out_sel][c]), exp_acc);
                end
            end
            if (done) begin
                done_cnt++;
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = q_done.pop_front();
                    chk("done_cyc", cyc, e.cyc);
                end
            end
        end
    end

    // Expected events of a job whose start is sampled at the end of cycle c0.
    task automatic push_job(input int k, input int c0);
        int l;
        q_pr.push_back(mk(c0 + 1, 0));
        if (k == 0) begin
            q_done.push_back(mk(c0 + 2, 0));
        end else begin
            l = k + ROWS + COLS - 2;
            for (int i = 0; i < k; i++) q_rd.push_back(mk(c0 + 2 + i, i));
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < k; i++) q_fire[r].push_back(c0 + 2 + i + r);
            for (int j = 0; j < ROWS; j++) q_ov.push_back(mk(c0 + 2 + l + j, j));
            q_done.push_back(mk(c0 + 2 + l + ROWS, 0));
        end
        exp_acc = (k * op_val * op_val) % 4096;
    endtask

    // Drop expectations after cycle cut (job cancelled by reset or abort).
    task automatic prune(input int cut);
        while (q_rd.size() > 0 && q_rd[$].cyc > cut) void'(q_rd.pop_back());
        while (q_ov.size() > 0 && q_ov[$].cyc > cut) void'(q_ov.pop_back());
        while (q_done.size() > 0 && q_done[$].cyc > cut) void'(q_done.pop_back());
        while (q_pr.size() > 0 && q_pr[$].cyc > cut) void'(q_pr.pop_back());
        for (int r = 0; r < ROWS; r++)
            while (q_fire[r].size() > 0 && q_fire[r][$] > cut) void'(q_fire[r].pop_back());
    endtask

    task automatic job_start(input int k, input bit with_abort);
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = KW'(k);
        abort = with_abort;
        push_job(k, cyc);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_pe_rstn"},   int'(pe_rstn), 1);
        chk({tag, "_rd_en"},     int'(rd_en), 0);
        chk({tag, "_rd_idx"},    int'(rd_idx), 0);
        chk({tag, "_fire_row"},  int'(fire_row), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_sel"},   int'(out_sel), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int c0;
        int left;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("init");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset in the middle of STREAM, then a fresh K=5 job.
        job_start(5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        prune(cyc);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset("midrst");
        end
        rst = 1'b0;

        base = done_cnt;
        job_start(5, 1'b0);
        wait_done(base + 1, 100);

        // K=0: CLEAR straight to DONE.
        base = done_cnt;
        job_start(0, 1'b0);
        wait_done(base + 1, 20);

        // Abort at STREAM s=3.
        base = done_cnt;
        job_start(5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        prune(cyc);
        q_pr.push_back(mk(cyc + 1, 0));
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy",      int'(busy), 0);
        chk("abort_rd_en",     int'(rd_en), 0);
        chk("abort_fire_row",  int'(fire_row), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_pe_rstn",   int'(pe_rstn), 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt, base);

        // Restart with abort also high in IDLE: start must win.
        base = done_cnt;
        job_start(2, 1'b1);
        wait_done(base + 1, 100);

        // start held high through a K=1 job: second job starts the cycle after DONE.
        base = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = KW'(1);
        c0    = cyc;
        push_job(1, c0);
        push_job(1, c0 + 14);
        repeat (15) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(base + 2, 100);

        // Full-length jobs through the array model.
        op_val = 1;
        base = done_cnt;
        job_start(255, 1'b0);
        wait_done(base + 1, 400);

        op_val = 16;
        base = done_cnt;
        job_start(255, 1'b0);
        wait_done(base + 1, 400);

        repeat (3) @(negedge clk);
        chk("left_rd",   q_rd.size(), 0);
        chk("left_ov",   q_ov.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("left_pr",   q_pr.size(), 0);
        left = 0;
        for (int r = 0; r < ROWS; r++) left += q_fire[r].size();
        chk("left_fire", left, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
